// File: rtl/onchip_mem_byte_loader_pkg.sv
// Shared types and constants for the on-chip RAM byte loader.
// Optional read-back verification is enabled by LOADER_READBACK_EN.
package onchip_mem_byte_loader_pkg;

    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_RD_ADDR,
        S_RD_CMP,
        S_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] lane_mask(
        input logic [BYTES_PER_WORD-1:0] be
    );
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/onchip_mem_byte_loader_packer.sv
// Little-endian byte-to-word packer: tracks the lane, accumulates
// writedata/byteenable and flags when a word is ready to write.
module onchip_mem_byte_packer
    import onchip_mem_byte_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      accept,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    output logic [DATA_W-1:0]         writedata,
    output logic [BYTES_PER_WORD-1:0] byteenable,
    output logic                      word_ready
);

    logic [LANE_W-1:0] lane;

    localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(BYTES_PER_WORD - 1);

    assign word_ready = accept && (lane == TOP_LANE || in_last);

    // Data is zeroed on clear so a short final word has 0 in unused lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane       <= '0;
            writedata  <= '0;
            byteenable <= '0;
        end else if (clear) begin
            lane       <= '0;
            writedata  <= '0;
            byteenable <= '0;
        end else if (accept) begin
            writedata[8*int'(lane) +: 8] <= in_data;
            byteenable[lane]             <= 1'b1;
            lane                         <= lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/onchip_mem_byte_loader.sv
// Avalon-MM byte-stream loader into a 32-bit on-chip RAM.
// Define LOADER_READBACK_EN to add a read-back check after every write.
module onchip_mem_byte_loader
    import onchip_mem_byte_loader_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      err_overflow,
    output logic                      err_verify,
    output logic [ADDR_W:0]           words_written,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [ADDR_W-1:0]         address,
    output logic [BYTES_PER_WORD-1:0] byteenable,
    output logic                      chipselect,
    output logic                      write,
    output logic [DATA_W-1:0]         writedata,
    input  logic [DATA_W-1:0]         readdata,
    output logic                      clken
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t state, state_n;

    logic [ADDR_W-1:0] addr;
    logic              last_seen;
    logic              base_bad;
    logic              load;
    logic              pk_clear;
    logic              accept;
    logic              word_ready;
    logic              word_end;
    logic              inc_addr;
    logic              set_ovf;
    logic              set_ver;

    assign base_bad = int'(base_addr) >= DEPTH;

    onchip_mem_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .accept     (accept),
        .in_data    (in_data),
        .in_last    (in_last),
        .writedata  (writedata),
        .byteenable (byteenable),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        pk_clear = 1'b0;
        accept   = 1'b0;
        word_end = 1'b0;
        inc_addr = 1'b0;
        set_ovf  = 1'b0;
        set_ver  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    pk_clear = 1'b1;
                    state_n  = base_bad ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                accept = in_valid;
                if (word_ready) state_n = S_WRITE;
            end
`ifdef LOADER_READBACK_EN
            S_WRITE:   state_n = S_RD_ADDR;
            S_RD_ADDR: state_n = S_RD_CMP;
            S_RD_CMP: begin
                word_end = 1'b1;
                set_ver  = ((readdata ^ writedata)
                            & lane_mask(byteenable)) != '0;
            end
`else
            S_WRITE:   word_end = 1'b1;
`endif
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        // A finished word either ends the load or advances to the next address.
        if (word_end) begin
            if (last_seen) begin
                state_n = S_DONE;
            end else if (addr == LAST_ADDR) begin
                set_ovf = 1'b1;
                state_n = S_DONE;
            end else begin
                inc_addr = 1'b1;
                pk_clear = 1'b1;
                state_n  = S_COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr          <= '0;
            words_written <= '0;
            err_overflow  <= 1'b0;
            last_seen     <= 1'b0;
        end else if (load) begin
            addr          <= base_addr;
            words_written <= '0;
            err_overflow  <= base_bad;
            last_seen     <= 1'b0;
        end else begin
            if (inc_addr) addr <= addr + ADDR_W'(1);
            if (set_ovf) err_overflow <= 1'b1;
            if (state == S_WRITE)
                words_written <= words_written + (ADDR_W+1)'(1);
            if (accept && in_last) last_seen <= 1'b1;
        end
    end

`ifdef LOADER_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     err_verify <= 1'b0;
        else if (load)    err_verify <= 1'b0;
        else if (set_ver) err_verify <= 1'b1;
    end
`else
    logic readdata_unused;
    assign readdata_unused = ^readdata;
    assign err_verify      = 1'b0;
`endif

    assign busy       = state != S_IDLE;
    assign done       = state == S_DONE;
    assign in_ready   = state == S_COLLECT;
    assign address    = addr;
    assign write      = state == S_WRITE;
    assign chipselect = state == S_WRITE || state == S_RD_ADDR;
    assign clken      = 1'b1;

endmodule

// File: doc/onchip_mem_byte_loader.md
# onchip_mem_byte_loader

Avalon-MM write master that sits directly upstream of the system's 32-bit single-port on-chip RAM (14-bit word address, 10000 words). It accepts a byte stream through a valid/ready handshake, such as an image arriving over a serial link. It packs the bytes little-endian into 32-bit words and writes them to consecutive word addresses from a programmable base. An optional read-back check verifies every word written.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the RAM port
- DEPTH, 10000, number of words; highest legal address is DEPTH-1

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts a load when idle, ignored otherwise
- base_addr  in  ADDR_W  first word address, sampled on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of load
- err_overflow  out  1  sticky; cleared on start
- err_verify  out  1  sticky; cleared on start; constant 0 without the macro
- words_written  out  ADDR_W+1  count of write cycles issued in the current or last load
- in_valid  in  1  byte available
- in_data  in  8  byte
- in_last  in  1  qualifies the final byte, valid with in_valid
- in_ready  out  1  byte accepted when in_valid and in_ready are both high
- address  out  ADDR_W  RAM word address
- byteenable  out  4  RAM byte lanes
- chipselect  out  1  RAM select
- write  out  1  RAM write strobe
- writedata  out  32  RAM write data
- readdata  in  32  RAM read data, valid 1 cycle after the read address is presented
- clken  out  1  RAM clock enable; constant 1 outside reset

## Operation
States: IDLE, COLLECT, WRITE, RD_ADDR, RD_CMP (the last two only with the macro), DONE.

- **IDLE**
  - in_ready=0.
  - start → COLLECT, with addr=base_addr, lane=0, words_written=0, errors cleared.
- **COLLECT**
  - in_ready=1.
  - Each accepted byte goes to writedata[8*lane+:8], sets byteenable[lane], and increments lane.
  - When the 4th byte or an in_last byte is accepted → WRITE.
- **WRITE** (exactly 1 cycle)
  - chipselect=1 and write=1, with the held address, byteenable and writedata.
  - words_written increments.
  - With the macro, the next state is RD_ADDR. Otherwise the next state follows the rules below.
- **After the write (or after RD_CMP)**
  - If the last byte was seen → DONE.
  - Else if addr==DEPTH-1 → err_overflow=1 and DONE.
  - Else addr increments, lane and byteenable clear, and the state returns to COLLECT.
- **Partial words**
  - A last byte arriving in lanes 0..2 writes with only the filled lanes enabled. Unwritten lanes of writedata are 0.
- **DONE**
  - done=1 for one cycle, then IDLE.
- **Outside WRITE/RD_ADDR**
  - chipselect=0 and write=0.
  - address, byteenable and writedata hold their last values.
- **start while busy** is ignored.
- **base_addr ≥ DEPTH** at start: err_overflow=1 immediately, the state goes DONE, and no write is issued.
- **Address never wraps.**

## Timing
- Reset values:
  - All outputs 0, except clken=1.
  - State is IDLE.
- busy is asserted the cycle after start. in_ready rises in that same cycle.
- The 4th byte accepted at cycle N produces write=1 at N+1. in_ready=0 at N+1, returning to 1 at N+2.
- Throughput without the macro is 4 bytes per 5 cycles.
- done pulses 1 cycle after the final WRITE, or 1 cycle after the final RD_CMP with the macro.
- reset_n asserted mid-load aborts immediately. No partial word is written after release.

## Configuration
- LOADER_READBACK_EN defined:
  - After every WRITE, RD_ADDR drives chipselect=1, write=0 at the same address.
  - RD_CMP compares readdata with writedata on the enabled lanes only. Any mismatch sets err_verify.
  - The load continues after a mismatch.
  - Throughput is 4 bytes per 7 cycles.
- Not defined:
  - RD_ADDR and RD_CMP do not exist, and readdata is unused.
  - err_verify is constant 0.

## Structure
- Shared package holds:
  - The state enum.
  - Constants DATA_W=32, BYTES_PER_WORD=4.
  - The lane-index width.
- One natural sub-module: onchip_mem_byte_packer. It owns lane, writedata and byteenable accumulation and flags word-ready. The FSM, address counter, and error flags stay in the top.

## Test plan
- base=0x0010, bytes 11 22 33 44 55 66 77 88 (last on 88) → writes 0x44332211 at 0x0010 and 0x88776655 at 0x0011, both byteenable=4'hF; words_written=2; done pulses; no errors.
- base=0x0020, bytes AA BB (last on BB) → one write 0x0000BBAA at 0x0020, byteenable=4'h3.
- base=DEPTH-1, 8 bytes with no last → one write at 0x270F, err_overflow=1, done; in_ready stays 0 afterwards.
- in_valid toggled randomly and a start pulse issued mid-load → packing is unaffected, start is ignored, and the data matches the stream.
- reset_n pulled low after 2 bytes → all outputs at reset values, no write issued; a new load then completes normally.
- LOADER_READBACK_EN with a RAM model that corrupts bit 0 of address 0x0005, loading 4 words from 0x0004 → err_verify=1, all 4 words written, done.
